// File: rtl/crc_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : crc_frame_tx
// Description : Frame serializer placed directly upstream of a serial CRC
//               generator. Accepts one parallel word through a valid/busy
//               handshake and shifts it out LSB-first on SER_DATA with
//               CRC_ACTIVE high. After a one-cycle gap, it forwards the
//               generator's serial CRC bits onto the same transmit line.
//               It flags a missing CRC_VALID and pulses FRAME_DONE when
//               the frame completes.
//
// Ports       : clk, rst        - clock (rising edge), synchronous active-high reset
//               i_p_data        - parallel payload, captured on accept
//               i_data_valid    - payload request, honoured only while idle
//               o_busy          - high whenever a frame is in progress
//               o_ser_data      - registered payload bit to CRC generator DATA
//               o_crc_active    - registered CRC generator ACTIVE
//               i_crc_bit       - serial CRC bit from the generator
//               i_crc_valid     - CRC bit valid from the generator
//               o_tx_out        - serial line (idle level 1)
//               o_tx_en         - high while o_tx_out carries a frame bit
//               o_frame_done    - one-cycle pulse after the last CRC bit
//               o_crc_err       - sticky: CRC_VALID was low during a CRC bit
//
// Revision    : 1.0 - initial release
// ============================================================================
module crc_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    output logic                  o_busy,
    output logic                  o_ser_data,
    output logic                  o_crc_active,
    input  logic                  i_crc_bit,
    input  logic                  i_crc_valid,
    output logic                  o_tx_out,
    output logic                  o_tx_en,
    output logic                  o_frame_done,
    output logic                  o_crc_err
);

    localparam int c_MAX_W = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
    localparam int c_CNT_W = $clog2(c_MAX_W) + 1;

    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CRC_LAST  = c_CNT_W'(CRC_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_GAP  = 2'd2,
        ST_CRC  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_ser;
    logic                    r_crc_active;
    logic                    r_frame_done;
    logic                    r_crc_err;

    logic [DATA_WIDTH-1:0]   w_shift_next;

    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_ser        <= 1'b0;
            r_crc_active <= 1'b0;
            r_frame_done <= 1'b0;
            r_crc_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_data_valid) begin
                        // Bit 0 is presented in the very first DATA cycle,
                        // so it is registered straight from the input here.
                        r_shift      <= i_p_data;
                        r_ser        <= i_p_data[0];
                        r_cnt        <= '0;
                        r_crc_err    <= 1'b0;
                        r_crc_active <= 1'b1;
                        r_state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_shift <= w_shift_next;
                    if (r_cnt == c_DATA_LAST) begin
                        r_ser        <= 1'b0;
                        r_crc_active <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= ST_GAP;
                    end else begin
                        r_ser <= w_shift_next[0];
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_GAP: begin
                    // Generator latches its first CRC bit during this cycle.
                    r_cnt   <= '0;
                    r_state <= ST_CRC;
                end
                ST_CRC: begin
                    if (!i_crc_valid) begin
                        r_crc_err <= 1'b1;
                    end
                    if (r_cnt == c_CRC_LAST) begin
                        r_cnt        <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line outputs decode directly from the registered state; the CRC bit is
    // a deliberate combinational pass-through from the generator.
    always_comb begin
        o_tx_out = 1'b1;
        o_tx_en  = 1'b0;
        case (r_state)
            ST_DATA: begin
                o_tx_out = r_ser;
                o_tx_en  = 1'b1;
            end
            ST_CRC: begin
                o_tx_out = i_crc_bit;
                o_tx_en  = 1'b1;
            end
            default: begin
                o_tx_out = 1'b1;
                o_tx_en  = 1'b0;
            end
        endcase
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_ser_data   = r_ser;
    assign o_crc_active = r_crc_active;
    assign o_frame_done = r_frame_done;
    assign o_crc_err    = r_crc_err;

endmodule
`default_nettype wire
